// File: rtl/udma_jtag_fifo_pkg.sv
// Purpose : shared types and helpers for the JTAG FIFO uDMA channel sequencer.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
package udma_jtag_fifo_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic [1:0] DS_1B   = 2'd0;
    localparam logic [1:0] DS_2B   = 2'd1;
    localparam logic [1:0] DS_4B   = 2'd2;
    localparam logic [1:0] DS_RSVD = 2'd3;

    // Bytes moved by one beat; the reserved code behaves as a 4-byte beat.
    function automatic logic [2:0] beat_bytes(input logic [1:0] ds);
        logic [2:0] b;
        case (ds)
            DS_1B:   b = 3'd1;
            DS_2B:   b = 3'd2;
            DS_4B:   b = 3'd4;
            default: b = 3'd4;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udma_jtag_fifo_ch_slot.sv
// Purpose : one transfer descriptor register (addr, size, datasize, continuous, valid).
// Latency : load/clear take effect at the next clk_i edge; clear wins over load.
// Backpressure: none; the owner decides when to load or clear.
// Ports   : clk_i/rstn_i, clr, load, load_* descriptor in, descriptor + valid out.
module udma_jtag_fifo_ch_slot #(
    parameter int AW = 12,
    parameter int SW = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          clr,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [SW-1:0] load_size,
    input  logic [1:0]    load_datasize,
    input  logic          load_continuous,
    output logic [AW-1:0] addr,
    output logic [SW-1:0] size,
    output logic [1:0]    datasize,
    output logic          continuous,
    output logic          valid
);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr       <= '0;
            size       <= '0;
            datasize   <= '0;
            continuous <= 1'b0;
            valid      <= 1'b0;
        end else if (clr) begin
            addr       <= '0;
            size       <= '0;
            datasize   <= '0;
            continuous <= 1'b0;
            valid      <= 1'b0;
        end else if (load) begin
            addr       <= load_addr;
            size       <= load_size;
            datasize   <= load_datasize;
            continuous <= load_continuous;
            valid      <= 1'b1;
        end
    end

endmodule

// File: rtl/udma_jtag_fifo_ch_ctrl.sv
// Purpose : per-direction uDMA channel sequencer: issues L2 beats, holds one queued transfer,
//           reloads in continuous mode. Optional beat counter under UDMA_JTAG_FIFO_BEAT_CNT_EN.
// Latency : cfg_en_i to first req_o is 1 cycle; back-to-back transfers have no bubble.
// Backpressure: req_o/addr_o/datasize_o hold until gnt_i; only cfg_clr_i drops req_o early.
// Ports   : cfg_* register-interface side, req_o/gnt_i/addr_o/datasize_o beat side,
//           evt_o end-of-transfer pulse, beat_cnt_o completed-beat count (0 when not built).
module udma_jtag_fifo_ch_ctrl
    import udma_jtag_fifo_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_size_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic                      cfg_continuous_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_clr_i,
    output logic                      cfg_en_o,
    output logic                      cfg_pending_o,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
    output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
    output logic                      req_o,
    input  logic                      gnt_i,
    output logic [L2_AWIDTH_NOAL-1:0] addr_o,
    output logic [1:0]                datasize_o,
    output logic                      evt_o,
    output logic [15:0]               beat_cnt_o
);

    ch_state_e                 state_q;
    logic [L2_AWIDTH_NOAL-1:0] addr_q;
    logic [TRANS_SIZE-1:0]     left_q;
    logic                      evt_q;

    logic [L2_AWIDTH_NOAL-1:0] act_addr,  pend_addr;
    logic [TRANS_SIZE-1:0]     act_size,  pend_size;
    logic [1:0]                act_ds,    pend_ds;
    logic                      act_cont,  pend_cont;
    logic                      act_valid, pend_valid;

    logic       run, en_ok, fire, last, eot, start_idle;
    logic       act_load, act_clr, pend_load, pend_clr;
    logic [2:0] bb;

    assign run   = (state_q == ST_RUN);
    assign en_ok = cfg_en_i & (cfg_size_i != '0);
    assign bb    = beat_bytes(act_ds);
    // act_valid tracks RUN; requiring it keeps a beat from ever using an empty snapshot.
    assign fire  = run & act_valid & gnt_i & ~cfg_clr_i;
    assign last  = (left_q <= TRANS_SIZE'(bb));
    assign eot   = fire & last;
    assign start_idle = ~run & en_ok & ~cfg_clr_i;

    // An enable landing on the last beat bypasses the pending slot and overrides it.
    assign act_load  = ~cfg_clr_i & (start_idle | (eot & (en_ok | pend_valid)));
    assign act_clr   = cfg_clr_i | (eot & ~en_ok & ~pend_valid & ~act_cont);
    assign pend_load = ~cfg_clr_i & run & en_ok & ~eot;
    assign pend_clr  = cfg_clr_i | (eot & pend_valid);

    udma_jtag_fifo_ch_slot #(.AW(L2_AWIDTH_NOAL), .SW(TRANS_SIZE)) u_act_slot (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .clr             (act_clr),
        .load            (act_load),
        .load_addr       (en_ok ? cfg_startaddr_i  : pend_addr),
        .load_size       (en_ok ? cfg_size_i       : pend_size),
        .load_datasize   (en_ok ? cfg_datasize_i   : pend_ds),
        .load_continuous (en_ok ? cfg_continuous_i : pend_cont),
        .addr            (act_addr),
        .size            (act_size),
        .datasize        (act_ds),
        .continuous      (act_cont),
        .valid           (act_valid)
    );

    udma_jtag_fifo_ch_slot #(.AW(L2_AWIDTH_NOAL), .SW(TRANS_SIZE)) u_pend_slot (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .clr             (pend_clr),
        .load            (pend_load),
        .load_addr       (cfg_startaddr_i),
        .load_size       (cfg_size_i),
        .load_datasize   (cfg_datasize_i),
        .load_continuous (cfg_continuous_i),
        .addr            (pend_addr),
        .size            (pend_size),
        .datasize        (pend_ds),
        .continuous      (pend_cont),
        .valid           (pend_valid)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            evt_q   <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            if (cfg_clr_i) begin
                state_q <= ST_IDLE;
                addr_q  <= '0;
                left_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (en_ok) begin
                            state_q <= ST_RUN;
                            addr_q  <= cfg_startaddr_i;
                            left_q  <= cfg_size_i;
                        end
                    end
                    ST_RUN: begin
                        if (fire) begin
                            if (last) begin
                                evt_q <= 1'b1;
                                if (en_ok) begin
                                    addr_q <= cfg_startaddr_i;
                                    left_q <= cfg_size_i;
                                end else if (pend_valid) begin
                                    addr_q <= pend_addr;
                                    left_q <= pend_size;
                                end else if (act_cont) begin
                                    addr_q <= act_addr;
                                    left_q <= act_size;
                                end else begin
                                    state_q <= ST_IDLE;
                                    addr_q  <= '0;
                                    left_q  <= '0;
                                end
                            end else begin
                                // Not the last beat, so left_q > bb and no underflow occurs.
                                addr_q <= addr_q + L2_AWIDTH_NOAL'(bb);
                                left_q <= left_q - TRANS_SIZE'(bb);
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // addr_q/left_q are forced to 0 on every entry to IDLE, so they double as the status view.
    assign cfg_en_o         = run;
    assign req_o            = run;
    assign cfg_pending_o    = pend_valid;
    assign cfg_curr_addr_o  = addr_q;
    assign cfg_bytes_left_o = left_q;
    assign addr_o           = addr_q;
    assign datasize_o       = act_ds;
    assign evt_o            = evt_q;

`ifdef UDMA_JTAG_FIFO_BEAT_CNT_EN
    logic [15:0] beat_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            beat_cnt_q <= '0;
        end else if (cfg_clr_i) begin
            beat_cnt_q <= '0;
        end else if (fire && (beat_cnt_q != 16'hFFFF)) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    assign beat_cnt_o = beat_cnt_q;
`else
    assign beat_cnt_o = 16'h0;
`endif

endmodule

// File: doc/udma_jtag_fifo_ch_ctrl.md
Name: udma_jtag_fifo_ch_ctrl

Overview:
Per-direction uDMA channel sequencer for the JTAG FIFO peripheral. It consumes the start address, size, continuous, enable and clear settings produced by the peripheral register interface. It emits a stream of L2 beat requests, tracks current address and bytes left for read-back, and holds one queued (pending) transfer. It also reloads automatically in continuous mode. One instance serves RX and one serves TX.

Parameters:
L2_AWIDTH_NOAL, 12, width of L2 word/byte address in bits
TRANS_SIZE, 16, width of transfer size / bytes-left counter in bits

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
cfg_startaddr_i  in  L2_AWIDTH_NOAL  start address of the next transfer
cfg_size_i  in  TRANS_SIZE  transfer length in bytes
cfg_datasize_i  in  2  beat width: 0=1B, 1=2B, 2=4B, 3=reserved (treated as 4B)
cfg_continuous_i  in  1  reload at end of transfer
cfg_en_i  in  1  single-cycle pulse: launch or queue a transfer
cfg_clr_i  in  1  single-cycle pulse: abort everything
cfg_en_o  out  1  transfer active (RUN)
cfg_pending_o  out  1  queued transfer present
cfg_curr_addr_o  out  L2_AWIDTH_NOAL  address of next beat (0 when idle)
cfg_bytes_left_o  out  TRANS_SIZE  bytes remaining (0 when idle)
req_o  out  1  beat request
gnt_i  in  1  beat accepted (handshake completes on req_o & gnt_i)
addr_o  out  L2_AWIDTH_NOAL  beat address
datasize_o  out  2  beat width code
evt_o  out  1  one-cycle end-of-transfer event
beat_cnt_o  out  16  beat counter (optional feature)

Behaviour:
- Reset: state IDLE. All outputs 0. Pending slot empty. Snapshot registers 0.
- States: IDLE, RUN.
- IDLE + cfg_en_i with cfg_size_i != 0:
  - Snapshot start address, size, datasize and continuous.
  - Next cycle: RUN, req_o=1, addr_o=start address, bytes_left=size.
  - Latency: 1 cycle.
- cfg_en_i with cfg_size_i == 0: ignored. No state change, no event.
- RUN + cfg_en_i (size != 0): written into the pending slot; cfg_pending_o=1 next cycle. If the slot is already full, it is overwritten (last write wins).
- Beat (req_o & gnt_i):
  - addr += beat bytes, modulo 2^L2_AWIDTH_NOAL (wraps).
  - bytes_left -= beat bytes, saturating at 0.
- Last beat: a beat where bytes_left <= beat bytes. A partial final beat is issued at full datasize width.
- End of transfer, on the clock edge of the last beat:
  - evt_o=1 for exactly one cycle.
  - If pending: load the pending slot, clear the pending flag, stay RUN, req_o stays 1 with the new address next cycle (no bubble).
  - Else if snapshot continuous=1: reload from the snapshot start address and size, stay RUN.
  - Else: IDLE, req_o=0, cfg_en_o=0.
- Simultaneous cfg_en_i and last beat: the enable is treated as pending, then consumed at the same edge. The new transfer starts directly and cfg_pending_o stays 0.
- Handshake: addr_o and datasize_o are stable while req_o & ~gnt_i. req_o is not dropped without a grant, except on clear.
- cfg_clr_i:
  - Highest priority over en and beats in the same cycle.
  - Next cycle: IDLE, pending empty, req_o=0, counters 0, no evt_o.
  - A grant coinciding with clr is discarded.
- cfg_curr_addr_o and cfg_bytes_left_o are registered, equal to the addr and bytes_left registers in RUN, and 0 in IDLE.
- Reset asserted mid-transfer: immediate asynchronous return to reset values.

Optional Feature:
Macro UDMA_JTAG_FIFO_BEAT_CNT_EN.
- Defined: 16-bit counter of completed beats.
  - Increments on each req_o & gnt_i and saturates at 16'hFFFF.
  - Cleared by cfg_clr_i and by reset; not cleared at end of transfer.
  - Drives beat_cnt_o.
- Undefined: counter not built; beat_cnt_o tied to 16'h0.

Decomposition:
- Shared package udma_jtag_fifo_pkg:
  - State enum type (IDLE, RUN).
  - Datasize code constants.
  - Function datasize-to-beat-bytes returning 1/2/4.
- Sub-module udma_jtag_fifo_ch_slot: a register bundle (addr, size, datasize, continuous, valid) with load/clear. Instantiated twice: active snapshot and pending slot.

Test Plan:
- Single transfer: start 0x100, size 8, datasize 2, gnt_i always 1 -> req_o for 2 cycles, addresses 0x100 then 0x104, evt_o one cycle after the 2nd beat edge, then IDLE with cfg_bytes_left_o=0.
- Queue: in RUN (start 0x000, size 16, 4B), en with start 0x200, size 4 -> cfg_pending_o=1; after 4 beats, next addr_o=0x200 with no idle cycle, pending cleared, two evt_o pulses total.
- Continuous with wrap: start 0xFFC, size 8, 4B, continuous -> addresses 0xFFC, 0x000, then 0xFFC again; evt_o every 2 beats.
- Backpressure: gnt_i low 3 cycles -> addr_o/datasize_o stable, bytes_left unchanged.
- Clear mid-transfer: clr during req_o with gnt_i=1 and pending full -> next cycle IDLE, req_o=0, pending 0, no evt_o, beat_cnt_o=0.
- Edge cases: en with size 0 ignored; en coinciding with the last beat -> new transfer starts and cfg_pending_o never rises; size 5 at 2B -> 3 beats.
